// File: rtl/latch_bank_arbiter.sv
// Round-robin write arbiter for a shared bank of level-sensitive D latches.
// Sequences setup/enable/hold around each write and checks the readback.
module latch_bank_arbiter #(
   parameter int WIDTH     = 8,
   parameter int EN_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0]   latch_q,
   output logic [WIDTH-1:0]   latch_d,
   output logic               latch_en,
   output logic [3:0]         grant,
   output logic [3:0]         ack,
   output logic               busy,
   output logic               err
);

   typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

   localparam logic [3:0] EN_LOAD = 4'(EN_CYCLES - 1);

   state_t           state, stateNext;
   logic [1:0]       lastGrant, lastGrantNext;
   logic [1:0]       winner;
   logic             winnerFound;
   logic [3:0]       enCount, enCountNext;
   logic [WIDTH-1:0] dataReg, dataRegNext;
   logic [WIDTH-1:0] slot [4];
   logic [3:0]       grantNext, ackNext;
   logic             latchEnNext, busyNext, errNext;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         slot[i] = data_in[i*WIDTH +: WIDTH];
      end
   end

   // Walk offsets from farthest to nearest so the requester just after lastGrant wins.
   always_comb begin
      logic [1:0] cand;
      winner      = lastGrant;
      winnerFound = 1'b0;
      cand        = lastGrant;
      for (int i = 4; i >= 1; i--) begin
         cand = lastGrant + 2'(i);
         if (req[cand]) begin
            winner      = cand;
            winnerFound = 1'b1;
         end
      end
   end

   always_comb begin
      stateNext     = state;
      lastGrantNext = lastGrant;
      enCountNext   = enCount;
      dataRegNext   = dataReg;
      grantNext     = grant;
      ackNext       = 4'b0000;
      latchEnNext   = 1'b0;
      busyNext      = busy;
      errNext       = err;
      case (state)
         IDLE: begin
            if (winnerFound) begin
               stateNext     = SETUP;
               lastGrantNext = winner;
               dataRegNext   = slot[winner];
               grantNext     = 4'b0001 << winner;
               busyNext      = 1'b1;
            end
         end
         SETUP: begin
            stateNext   = ENABLE;
            enCountNext = EN_LOAD;
            latchEnNext = 1'b1;
         end
         // Enable stays high while the counter drains; ack is raised on entry to HOLD.
         ENABLE: begin
            if (enCount == 4'd0) begin
               stateNext = HOLD;
               ackNext   = grant;
            end else begin
               enCountNext = enCount - 4'd1;
               latchEnNext = 1'b1;
            end
         end
         HOLD: begin
            if (latch_q != dataReg) begin
               errNext = 1'b1;
            end
            grantNext = 4'b0000;
            busyNext  = 1'b0;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lastGrant <= 2'd3;
         enCount   <= 4'd0;
         dataReg   <= '0;
         grant     <= 4'b0000;
         ack       <= 4'b0000;
         latch_en  <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= stateNext;
         lastGrant <= lastGrantNext;
         enCount   <= enCountNext;
         dataReg   <= dataRegNext;
         grant     <= grantNext;
         ack       <= ackNext;
         latch_en  <= latchEnNext;
         busy      <= busyNext;
         err       <= errNext;
      end
   end

   assign latch_d = dataReg;

endmodule
